telemetry_framer: RTL and testbench
===================================

TELEMETRY_FRAMER -- requirements
Module: telemetry_framer

Interface
REQ-001 The module SHALL declare parameter N_BYTES, default 41, giving the payload byte count (range 1..255).
REQ-002 The module SHALL declare parameter PERIOD, default 5000000, giving the clk cycles between automatic frames (10 Hz at 50 MHz).
REQ-003 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: the system clock.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port start, input, 1 bit: a 1-cycle request for an immediate frame.
REQ-007 Port addr, output, 8 bits: the sensor register address.
REQ-008 Port data, input, 8 bits: the sensor register byte, valid 1 cycle after addr.
REQ-009 Port tx_data, output, 8 bits: the byte sent to the serial transmitter.
REQ-010 Port new_data, output, 1 bit: a 1-cycle strobe that launches tx_data.
REQ-011 Port tx_busy, input, 1 bit: transmitter busy.
REQ-012 Port tx_block, input, 1 bit: transmitter flow-control hold.
REQ-013 Port frame_busy, output, 1 bit: high while a frame is in progress.
REQ-014 Port frame_done, output, 1 bit: a 1-cycle pulse after the last byte is accepted.
REQ-015 Port overrun, output, 1 bit: a 1-cycle pulse when a trigger arrives while frame_busy is high.

Function
REQ-016 The block SHALL send each frame as: 0xA5, 0x5A, SEQ, N_BYTES, payload[0..N_BYTES-1], CK, for N_BYTES+5 bytes in total.
REQ-017 payload[k] SHALL be the data value returned for addr = k.
REQ-018 The block SHALL present addr = k one cycle before it captures data; capture is a registered 1-cycle read.
REQ-019 CK SHALL equal (256 - (SEQ + N_BYTES + sum of payload) mod 256) mod 256, so that the 8-bit sum of every byte from SEQ through CK is 0.
REQ-020 SEQ SHALL increment by 1 after each completed frame and wrap from 255 to 0.
REQ-021 The period counter SHALL be 23 bits wide, count 0..PERIOD-1, and generate a trigger when it wraps; it runs continuously and is not gated by frame activity.
REQ-022 A trigger is defined as start=1 or a period wrap; both in the same cycle SHALL count as one trigger.
REQ-023 A trigger while frame_busy=0 SHALL start a frame, with frame_busy going high the next cycle.
REQ-024 A trigger while frame_busy=1 SHALL be dropped and SHALL pulse overrun for one cycle.
REQ-025 The state machine SHALL have the states IDLE, FETCH, CAPTURE, SEND, HOLD and DRAIN.
REQ-026 In IDLE, a trigger SHALL clear the byte index and the checksum accumulator and move to FETCH.
REQ-027 FETCH SHALL select the next byte: header, SEQ and LEN bytes go straight to SEND; payload bytes drive addr and move to CAPTURE; the final byte loads CK.
REQ-028 CAPTURE SHALL latch data into tx_data and move to SEND.
REQ-029 SEND SHALL wait until tx_busy=0 and tx_block=0, then pulse new_data for exactly 1 cycle, add the byte to the accumulator if it is in the checksummed range, and move to HOLD.
REQ-030 HOLD SHALL last 1 cycle, covering the transmitter's busy latency, and then move to DRAIN.
REQ-031 DRAIN SHALL wait for tx_busy=0; it then goes to FETCH with the index incremented, or, after the last byte, pulses frame_done, increments SEQ and goes to IDLE.
REQ-032 tx_data SHALL remain stable from SEND through the end of HOLD.
REQ-033 Raising tx_block mid-frame SHALL only stall SEND; no byte may be dropped or duplicated.
REQ-034 new_data SHALL never assert while tx_busy=1 or tx_block=1.
REQ-035 A single frame SHALL produce exactly N_BYTES+5 new_data pulses.

Reset
REQ-036 rst_n=0 SHALL immediately return the state to IDLE.
REQ-037 During reset, addr SHALL be 0x00, tx_data 0x00, new_data 0, frame_busy 0, frame_done 0 and overrun 0.
REQ-038 During reset, SEQ and the period counter SHALL be 0 and the checksum accumulator 0.
REQ-039 Reset during a frame SHALL abort the frame with no further new_data, and SEQ SHALL not advance.
REQ-040 After rst_n deasserts, the first automatic trigger SHALL occur PERIOD cycles later.

Verification
REQ-041 Scenario: N_BYTES=4, reg[k]=k+1, pulse start with an ideal transmitter model (busy for 10 cycles) -> bytes A5 5A 00 04 01 02 03 04 F2, then frame_done, then SEQ=1.
REQ-042 Scenario: a second start issued while the REQ-041 frame is in progress -> overrun pulses once, only 9 bytes are sent, and the next frame carries SEQ=01.
REQ-043 Scenario: hold tx_block=1 for 200 cycles after byte 3 is accepted -> no new_data during the hold, and the stream is identical to REQ-041 after release.
REQ-044 Scenario: PERIOD=1000, start never asserted -> frames begin 1000 cycles apart, with SEQ wrapping 0xFF->0x00 after 256 frames and the checksum still summing to 0.
REQ-045 Scenario: assert rst_n=0 during payload byte 2 -> new_data is 0 immediately, all outputs hold reset values, and the next frame sends SEQ=00.
REQ-046 Scenario: start and a period wrap in the same cycle while idle -> exactly one frame and no overrun.

Source files
------------

// File: rtl/telemetry_framer.sv
// rtl/telemetry_framer.sv - periodic/on-demand telemetry framer reading sensor registers into a byte transmitter
module telemetry_framer #(
    parameter int N_BYTES = 41,
    parameter int PERIOD  = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] addr,
    input  logic [7:0] data,
    output logic [7:0] tx_data,
    output logic       new_data,
    input  logic       tx_busy,
    input  logic       tx_block,
    output logic       frame_busy,
    output logic       frame_done,
    output logic       overrun
);
    localparam logic [8:0]  LAST_IDX   = 9'(N_BYTES + 4);
    localparam logic [22:0] PERIOD_MAX = 23'(PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        SEND,
        HOLD,
        DRAIN
    } state_t;

    state_t      state;
    logic [22:0] period_cnt;
    logic [8:0]  idx;
    logic [8:0]  idx_nxt;
    logic [7:0]  seq;
    logic [7:0]  acc;
    logic        period_wrap;
    logic        trigger;
    logic        in_ck_range;

    assign period_wrap = (period_cnt == PERIOD_MAX);
    assign trigger     = start | period_wrap;
    assign idx_nxt     = idx + 9'd1;
    assign in_ck_range = (idx >= 9'd2) && (idx < LAST_IDX);
    // Decoded from current inputs so a strobe can never coincide with busy or block.
    assign new_data    = (state == SEND) && !tx_busy && !tx_block;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (period_wrap) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 23'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            seq        <= '0;
            acc        <= '0;
            addr       <= '0;
            tx_data    <= '0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            overrun    <= trigger & frame_busy;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        idx        <= '0;
                        acc        <= '0;
                        addr       <= '0;
                        frame_busy <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    if (idx == LAST_IDX) begin
                        tx_data <= 8'h00 - acc;
                        state   <= SEND;
                    end else if (idx >= 9'd4) begin
                        state <= CAPTURE;
                    end else begin
                        case (idx[1:0])
                            2'd0:    tx_data <= 8'hA5;
                            2'd1:    tx_data <= 8'h5A;
                            2'd2:    tx_data <= seq;
                            default: tx_data <= 8'(N_BYTES);
                        endcase
                        state <= SEND;
                    end
                end
                CAPTURE: begin
                    tx_data <= data;
                    state   <= SEND;
                end
                SEND: begin
                    if (new_data) begin
                        if (in_ck_range) begin
                            acc <= acc + tx_data;
                        end
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (!tx_busy) begin
                        if (idx == LAST_IDX) begin
                            frame_done <= 1'b1;
                            seq        <= seq + 8'd1;
                            frame_busy <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            // Address is issued here so the sensor's registered read lands in CAPTURE.
                            idx   <= idx_nxt;
                            addr  <= (idx_nxt >= 9'd4) ? 8'(idx_nxt - 9'd4) : 8'h00;
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_telemetry_framer.sv
// tb/tb_telemetry_framer.sv - randomized bench for telemetry_framer against a frame-level reference model
module tb_telemetry_framer;
    localparam int NB  = 4;
    localparam int PER = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       tx_block = 1'b0;
    logic [7:0] data = 8'h00;
    logic [7:0] addr;
    logic [7:0] tx_data;
    logic       new_data;
    logic       frame_busy;
    logic       frame_done;
    logic       overrun;
    wire        tx_busy;

    telemetry_framer #(.N_BYTES(NB), .PERIOD(PER)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .addr       (addr),
        .data       (data),
        .tx_data    (tx_data),
        .new_data   (new_data),
        .tx_busy    (tx_busy),
        .tx_block   (tx_block),
        .frame_busy (frame_busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    logic [7:0] regs [256];
    int         busy_cnt = 0;
    logic       nd_seen = 1'b0;

    assign tx_busy = (busy_cnt != 0);

    // Sensor: registered one-cycle read.
    always @(posedge clk) data <= regs[addr];

    // Transmitter: goes busy for a few cycles after each accepted byte.
    always @(posedge clk) begin
        if (nd_seen) busy_cnt <= $urandom_range(2, 12);
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q [$];
    logic [7:0] got [$];
    logic       active = 1'b0;
    logic       exp_ovr = 1'b0;
    logic [7:0] seq_m = 8'h00;
    int         cyc = 0;
    int         nbytes = 0;
    int         stall = 0;
    int         ovr_cnt = 0;
    int         frames_since_reset = 0;
    logic       lit_pending = 1'b0;
    logic [7:0] lit [9] = '{8'hA5, 8'h5A, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_frame();
        int s;
        s = int'(seq_m) + NB;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(seq_m);
        exp_q.push_back(8'(NB));
        for (int k = 0; k < NB; k++) begin
            exp_q.push_back(regs[k]);
            s += int'(regs[k]);
        end
        exp_q.push_back(8'((256 - (s % 256)) % 256));
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {addr, tx_data, new_data, frame_busy, frame_done, overrun}, 0);
            active = 1'b0;
            exp_ovr = 1'b0;
            seq_m = 8'h00;
            cyc = 0;
            nbytes = 0;
            stall = 0;
            frames_since_reset = 0;
            exp_q.delete();
            got.delete();
            nd_seen = 1'b0;
        end else begin
            chk("overrun", int'(overrun), int'(exp_ovr));
            if (overrun) ovr_cnt++;
            if (new_data) begin
                chk("nd_while_busy_or_block", int'(tx_busy | tx_block), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", int'(tx_data), -1);
                end else begin
                    chk("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
                end
                got.push_back(tx_data);
                nbytes++;
            end
            nd_seen = new_data;
            if (frame_done) begin
                int s;
                chk("done_byte_count", nbytes, NB + 5);
                chk("done_frame_busy", int'(frame_busy), 0);
                chk("done_while_active", int'(active), 1);
                s = 0;
                for (int i = 2; i < got.size(); i++) s += int'(got[i]);
                chk("frame_sum", s % 256, 0);
                if (lit_pending && got.size() == 9) begin
                    for (int i = 0; i < 9; i++) chk("literal_frame", int'(got[i]), int'(lit[i]));
                    lit_pending = 1'b0;
                end
                frames_since_reset++;
                seq_m = seq_m + 8'd1;
                active = 1'b0;
                nbytes = 0;
                got.delete();
            end else begin
                chk("frame_busy", int'(frame_busy), int'(active));
            end
            if (active && !new_data) stall++;
            else stall = 0;
            if (stall > 3000) begin
                chk("progress_timeout", stall, 0);
                stall = 0;
            end
            // Decide what the coming edge does: start and a period wrap together are one trigger.
            exp_ovr = 1'b0;
            if (start || (cyc % PER == PER - 1)) begin
                if (active) begin
                    exp_ovr = 1'b1;
                end else begin
                    active = 1'b1;
                    push_frame();
                end
            end
            cyc++;
        end
    end

    task automatic wait_nbytes(input int n);
        int t;
        for (t = 0; t < 5000 && !(active && nbytes >= n); t++) begin
            @(posedge clk);
            #1;
        end
        if (!(active && nbytes >= n)) chk("wait_bytes_timeout", t, 0);
    endtask

    task automatic wait_idle();
        int t;
        for (t = 0; t < 5000 && active; t++) begin
            @(posedge clk);
            #1;
        end
        if (active) chk("wait_idle_timeout", t, 0);
    endtask

    initial begin
        int ovr_before;
        int frames_before;
        int t;
        for (int k = 0; k < 256; k++) regs[k] = 8'(k + 1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Immediate frame with known payload, plus a second start mid-frame.
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        lit_pending = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_nbytes(4);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        chk("overrun_count", ovr_cnt, 1);

        // Flow-control hold after byte 3 of the next automatic frame.
        wait_nbytes(3);
        tx_block = 1'b1;
        repeat (200) @(posedge clk);
        #1 tx_block = 1'b0;
        wait_idle();

        // Reset during the payload.
        wait_nbytes(5);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Start coinciding with a period wrap while idle.
        for (t = 0; t < 1000 && !(!active && (cyc % PER) == PER - 1); t++) begin
            @(posedge clk);
            #1;
        end
        chk("align_to_wrap", int'(!active && (cyc % PER) == PER - 1), 1);
        ovr_before = ovr_cnt;
        frames_before = frames_since_reset;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();
        chk("coincident_overrun", ovr_cnt - ovr_before, 0);
        chk("coincident_frames", frames_since_reset - frames_before, 1);

        // Long randomized run: automatic frames, sporadic starts, stalls and payload changes.
        for (int i = 0; i < 62000; i++) begin
            start = ($urandom_range(0, 999) == 0);
            if (tx_block) tx_block = ($urandom_range(0, 19) != 0);
            else tx_block = ($urandom_range(0, 1999) == 0);
            if (!active && $urandom_range(0, 49) == 0) regs[$urandom_range(0, NB - 1)] = 8'($urandom);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        tx_block = 1'b0;
        wait_idle();
        chk("seq_wrapped", int'(frames_since_reset >= 257), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
